// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register layout.
// Imported by the fetch stage and its helpers.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts edges with inc=1, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register: owns the PC, applies flush > stall > advance,
// and keeps saturating stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IF_ID_pc,
    output logic [31:0]      IF_ID_pc_plus4,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic [4:0]       IF_ID_rs1,
    output logic [4:0]       IF_ID_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipeline_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_id_t      ifid_q;
    if_id_t      ifid_d;
    if_id_t      bubble;

    assign bubble = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (flush) begin
            // The stalled instruction is on the wrong path, so flush overrides stall.
            pc_d   = {branch_target[31:2], 2'b00};
            ifid_d = bubble;
        end else if (!stall) begin
            pc_d   = pc_q + 32'd4;
            ifid_d = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_q + 32'd4, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            ifid_q <= bubble;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign IF_ID_pc       = ifid_q.pc;
    assign IF_ID_pc_plus4 = ifid_q.pc_plus4;
    assign IF_ID_instr    = ifid_q.instr;
    assign IF_ID_valid    = ifid_q.valid;
    assign IF_ID_rs1      = ifid_q.valid ? ifid_q.instr[RS1_LSB +: REG_W] : 5'd0;
    assign IF_ID_rs2      = ifid_q.valid ? ifid_q.instr[RS2_LSB +: REG_W] : 5'd0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall & ~flush),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, corner-case sequences, and a
// randomized run against a cycle-level reference model.
module tb_if_id_stage;

    localparam int          CNT_W   = 16;
    localparam int          CNT_MAX = 65535;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    if_id_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_rs1      (IF_ID_rs1),
        .IF_ID_rs2      (IF_ID_rs2),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0ACE_1234;
    endfunction

    assign imem_rdata = imem_fn(imem_addr);

    // Reference model: architectural PC, the instruction held in IF/ID, and event counts.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    int          m_sc;
    int          m_fc;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [31:0] t);
        if (f) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
            if (m_fc < CNT_MAX) m_fc++;
        end else if (s) begin
            if (m_sc < CNT_MAX) m_sc++;
        end else begin
            m_instr = imem_fn(m_pc); m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_p4;
        logic [4:0]  e_rs1, e_rs2;
        e_p4  = m_valid ? m_ipc + 32'd4 : 32'h0;
        e_rs1 = m_valid ? m_instr[19:15] : 5'd0;
        e_rs2 = m_valid ? m_instr[24:20] : 5'd0;
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".pc"}, IF_ID_pc, m_ipc);
        chk({tag, ".pc_plus4"}, IF_ID_pc_plus4, e_p4);
        chk({tag, ".instr"}, IF_ID_instr, m_instr);
        chk({tag, ".valid"}, 32'(IF_ID_valid), 32'(m_valid));
        chk({tag, ".rs1"}, 32'(IF_ID_rs1), 32'(e_rs1));
        chk({tag, ".rs2"}, 32'(IF_ID_rs2), 32'(e_rs2));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_fc));
    endtask

    // One clock: apply inputs, clock, sample 1 time unit after the edge.
    task automatic step(input logic s, input logic f, input logic [31:0] t);
        stall = s; flush = f; branch_target = t;
        model_step(s, f, t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b1; flush = 1'b1; branch_target = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        stall = 1'b0; flush = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic        f;
        logic [31:0] t;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        int          e_sc;
        int          e_fc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] e_instr;
        logic s, f;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;

        //          s     f     target        addr          IF_ID_pc      valid sc fc
        vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 1'b1, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 1'b1, 0, 0};
        vecs[2] = '{1'b1, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 1'b1, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 1'b1, 2, 0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        32'h0000_000C, 32'h0000_0008, 1'b1, 2, 0};
        vecs[5] = '{1'b1, 1'b1, 32'h40,       32'h0000_0040, 32'h0000_0000, 1'b0, 2, 1};
        vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0000_0044, 32'h0000_0040, 1'b1, 2, 1};
        vecs[7] = '{1'b0, 1'b1, 32'h43,       32'h0000_0040, 32'h0000_0000, 1'b0, 2, 2};
        vecs[8] = '{1'b0, 1'b1, 32'h80,       32'h0000_0080, 32'h0000_0000, 1'b0, 2, 3};
        vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0000_0084, 32'h0000_0080, 1'b1, 2, 3};

        do_reset();
        check_model("reset");
        chk("reset.imem_addr_lit", imem_addr, 32'h0);
        chk("reset.instr_lit", IF_ID_instr, NOP);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].s, vecs[i].f, vecs[i].t);
            e_instr = vecs[i].e_valid ? imem_fn(vecs[i].e_pc) : NOP;
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d.pc", i), IF_ID_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.pc_plus4", i), IF_ID_pc_plus4,
                vecs[i].e_valid ? vecs[i].e_pc + 32'd4 : 32'h0);
            chk($sformatf("vec%0d.instr", i), IF_ID_instr, e_instr);
            chk($sformatf("vec%0d.valid", i), 32'(IF_ID_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.rs1", i), 32'(IF_ID_rs1),
                vecs[i].e_valid ? 32'(e_instr[19:15]) : 32'h0);
            chk($sformatf("vec%0d.rs2", i), 32'(IF_ID_rs2),
                vecs[i].e_valid ? 32'(e_instr[24:20]) : 32'h0);
            chk($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_sc));
            chk($sformatf("vec%0d.flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].e_fc));
            if (i == 0) begin
                chk("first.instr_lit", IF_ID_instr, 32'h0050_0093);
                chk("first.rs2_lit", 32'(IF_ID_rs2), 32'd5);
            end
        end

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        check_model("wrap.redirect");
        chk("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check_model("wrap.advance");
        chk("wrap.addr_zero", imem_addr, 32'h0);
        chk("wrap.pc_plus4_zero", IF_ID_pc_plus4, 32'h0);

        // Asynchronous reset asserted mid-stall, between clock edges.
        step(1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b0, 32'h0);
        check_model("midstall.pre");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("midstall.async");
        @(posedge clk); #1;
        check_model("midstall.held");
        #2;
        rst_n = 1'b1;
        stall = 1'b0; flush = 1'b0;

        // Stall counter saturation.
        for (int i = 0; i < 65534; i++) step(1'b1, 1'b0, 32'h0);
        chk("sat.at_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        check_model("sat.fffe");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        chk("sat.at_ffff", 32'(stall_cnt), 32'h0000_FFFF);
        check_model("sat.ffff");
        step(1'b0, 1'b0, 32'h0);
        check_model("sat.resume");

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 99) < 30);
            f = ($urandom_range(0, 99) < 10);
            step(s, f, $urandom);
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage RV32I pipeline.
- Owns the PC and drives the instruction-memory address. Latches the fetched instruction, PC and PC+4 into IF/ID.
- Consumes the load-use `stall` from the hazard-detection unit and the taken-branch `flush`/target from EX.
- Feeds IF/ID rs1/rs2 back to hazard detection. Keeps stall/flush performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset/flush.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  load-use stall from hazard detection; hold PC and IF/ID
- flush  input  1  taken branch/jump resolved in EX; redirect and squash IF/ID
- branch_target  input  32  redirect PC, valid when flush=1
- imem_addr  output  32  instruction-memory address (= PC, combinational)
- imem_rdata  input  32  instruction word, combinational read of imem_addr
- IF_ID_pc  output  32  PC of the instruction in IF/ID
- IF_ID_pc_plus4  output  32  IF_ID_pc + 4
- IF_ID_instr  output  32  instruction in IF/ID
- IF_ID_valid  output  1  1 = real instruction, 0 = bubble
- IF_ID_rs1  output  5  IF_ID_instr[19:15]; 0 when IF_ID_valid=0
- IF_ID_rs2  output  5  IF_ID_instr[24:20]; 0 when IF_ID_valid=0
- stall_cnt  output  CNT_W  cycles with stall=1 and flush=0, saturating
- flush_cnt  output  CNT_W  cycles with flush=1, saturating

Behaviour:
- Reset, asynchronous on rst_n=0, effective immediately, including mid-stall or mid-flush:
  - PC=RESET_PC; IF_ID_instr=NOP_INSTR; IF_ID_valid=0.
  - IF_ID_pc=0; IF_ID_pc_plus4=0; stall_cnt=0; flush_cnt=0.
  - IF_ID_rs1 and IF_ID_rs2 are 0 because IF_ID_valid=0.
- imem_addr=PC at all times. The instruction at RESET_PC is captured into IF/ID on the first rising edge after rst_n deasserts.
- Per rising edge, priority flush > stall > advance:
  - flush=1:
    - PC <= {branch_target[31:2],2'b00}; bits [1:0] are forced to zero.
    - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc=0, pc_plus4=0.
    - stall is ignored because the stalled instruction is wrong-path.
  - stall=1, flush=0: PC and every IF/ID field hold their values; imem is re-read at the same address.
  - Otherwise: PC <= PC+4; IF/ID <= {imem_rdata, PC, PC+4}; valid <= 1.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: one cycle from imem_addr to IF/ID. A redirect fetches the target on the cycle after flush, and the target appears in IF/ID two edges after flush.
- Counters:
  - stall_cnt increments on each edge with stall&~flush.
  - flush_cnt increments on each edge with flush.
  - Both saturate at all-ones and never wrap.
- Back-to-back stalls hold indefinitely. Stall deasserting resumes with the held instruction advancing normally.
- A flush on consecutive cycles redirects to the latest branch_target each time.
- X on stall/flush during reset is ignored.

Decomposition:
- Shared package pipeline_pkg:
  - Constants NOP_INSTR and RESET_PC.
  - rs1/rs2 field bit positions.
  - A packed IF/ID struct {instr, pc, pc_plus4, valid}.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clk/rst_n), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset release with imem returning 32'h00500093 at 0 → after edge 1: IF_ID_pc=0, IF_ID_instr=32'h00500093, valid=1, rs1=0, rs2=5; imem_addr=4.
- Load-use: stall=1 for 2 cycles with PC=8 and IF_ID_pc=4 → PC stays 8 and IF/ID unchanged for both cycles; stall_cnt=2; advances normally on the third edge.
- flush=1 with branch_target=32'h40 while stall=1 → PC=32'h40, IF_ID_valid=0, IF_ID_instr=32'h00000013, rs1=rs2=0; flush_cnt=1, stall_cnt unchanged.
- branch_target=32'h43 on flush → imem_addr=32'h40.
- PC=32'hFFFFFFFC, no stall/flush → next PC=0 and IF_ID_pc_plus4=0.
- rst_n pulsed low mid-stall with PC=32'h20 → outputs immediately reach reset values; counters preset to 16'hFFFE with 3 stall cycles → stall_cnt ends at 16'hFFFF.
